// File: rtl/debounce_sync_if.sv
// ----------------------------------------------------------------------------
// debounce_sync_if
// Bundles the conditioning stage's raw inputs, sample tick and conditioned
// outputs. The slave side is the debounce block. The master side is whoever
// drives the raw lines and consumes the clean levels and pulses.
// Optional macro DEBOUNCE_GLITCH_CNT_EN adds the 16-bit glitch_cnt signal.
// ----------------------------------------------------------------------------
interface debounce_sync_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] din;        // raw asynchronous inputs
    logic             sample_en;  // debounce sample tick
    logic [WIDTH-1:0] dout;       // debounced, synchronized level
    logic [WIDTH-1:0] rise;       // one-cycle 0->1 pulse per bit
    logic [WIDTH-1:0] fall;       // one-cycle 1->0 pulse per bit
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [15:0]      glitch_cnt; // saturating count of aborted transitions

    modport master (
        output din,
        output sample_en,
        input  dout,
        input  rise,
        input  fall,
        input  glitch_cnt
    );

    modport slave (
        input  din,
        input  sample_en,
        output dout,
        output rise,
        output fall,
        output glitch_cnt
    );
`else
    modport master (
        output din,
        output sample_en,
        input  dout,
        input  rise,
        input  fall
    );

    modport slave (
        input  din,
        input  sample_en,
        output dout,
        output rise,
        output fall
    );
`endif
endinterface

// File: rtl/debounce_sync.sv
// ----------------------------------------------------------------------------
// debounce_sync
// Input conditioning for asynchronous external lines. Each bit runs through a
// SYNC_STAGES-deep flop chain and then its own debounce counter. A new level
// is accepted only after DEBOUNCE_CYCLES consecutive qualifying samples that
// disagree with the current output. Accepted changes produce registered,
// single-cycle rise/fall pulses that align with the new dout value.
//
// Optional macro DEBOUNCE_GLITCH_CNT_EN adds a saturating 16-bit counter of
// aborted transitions (edges where a partially counted change collapses).
// With the macro undefined that counter and its port do not exist.
// ----------------------------------------------------------------------------
module debounce_sync #(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    debounce_sync_if.slave bus
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; sized with one spare code.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Terminal count: the sample that, if still disagreeing, commits the change.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Elaboration-time sanity checks on the configuration.
    // ------------------------------------------------------------------------
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("debounce_sync: SYNC_STAGES must be at least 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
            $error("debounce_sync: DEBOUNCE_CYCLES must be at least 1");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("debounce_sync: WIDTH must be at least 1");
        end
    endgenerate

    // Module-level views of the per-bit state, assembled bit by bit below.
    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] dout_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // One bit per lane: set when that lane abandons a partial count this edge.
    logic [WIDTH-1:0] abort_w;
`endif

    // Single sample tick shared by all lanes.
    logic sample_en_w;
    assign sample_en_w = bus.sample_en;

    // ------------------------------------------------------------------------
    // Per-bit lanes: synchronizer, debounce counter, level and edge pulses.
    // Lanes share nothing except the sample tick, so they behave identically
    // and independently; simultaneous changes give simultaneous pulses.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            // Synchronizer chain; din feeds nothing else in this design.
            (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] chain_q;

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             level_q;
            logic             level_d;
            logic             rise_q;
            logic             rise_d;
            logic             fall_q;
            logic             fall_d;
            logic             sync_bit;
            logic             differs;
            logic             at_last;

            // Shift the raw input through the metastability chain.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    chain_q <= '0;
                end else begin
                    chain_q <= {chain_q[SYNC_STAGES-2:0], bus.din[gi]};
                end
            end

            assign sync_bit = chain_q[SYNC_STAGES-1];
            assign differs  = sync_bit ^ level_q;
            assign at_last  = (cnt_q == CNT_LAST);

            // Debounce decision: clear on agreement, hold without a tick,
            // count on a disagreeing tick, commit on the terminal tick.
            always_comb begin
                cnt_d   = cnt_q;
                level_d = level_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                if (!differs) begin
                    cnt_d = '0;
                end else if (sample_en_w) begin
                    if (at_last) begin
                        cnt_d   = '0;
                        level_d = sync_bit;
                        rise_d  = sync_bit;
                        fall_d  = ~sync_bit;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            // Register counter, accepted level and the edge pulses together so
            // a pulse is high exactly in the cycle the new level is visible.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                end
            end

            assign sync_w[gi] = sync_bit;
            assign dout_w[gi] = level_q;
            assign rise_w[gi] = rise_q;
            assign fall_w[gi] = fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
            // A nonzero count that meets an agreeing sample is a rejected glitch.
            assign abort_w[gi] = (cnt_q != '0) && !differs;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output assembly.
    // ------------------------------------------------------------------------
    assign bus.dout = dout_w;
    assign bus.rise = rise_w;
    assign bus.fall = fall_w;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // ------------------------------------------------------------------------
    // Glitch counter: at most one increment per edge however many lanes
    // abort together; sticks at all-ones so a busy line never looks quiet.
    // ------------------------------------------------------------------------
    logic [15:0] glitch_cnt_q;
    logic [15:0] glitch_cnt_d;

    // Next-state for the saturating glitch counter.
    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if ((|abort_w) && (glitch_cnt_q != 16'hFFFF)) begin
            glitch_cnt_d = glitch_cnt_q + 16'd1;
        end
    end

    // Glitch counter register; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign bus.glitch_cnt = glitch_cnt_q;
`endif

endmodule
